// File: rtl/fib_index_decoder.sv
// Inverse Fibonacci lookup: walks F0, F1, ... until the running term reaches or
// passes the accepted value, then reports the match flag and the index reached.
module fib_index_decoder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_is_fib,
  output logic [IDX_W-1:0] out_index,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StSearch, StDone} state_t;

  state_t           state;
  logic [WIDTH-1:0] target;
  // Two guard bits keep the running term from wrapping past the largest target.
  logic [WIDTH+1:0] a;
  logic [WIDTH+1:0] b;
  logic [IDX_W-1:0] idx;
  logic [WIDTH+1:0] target_ext;

  assign target_ext = {2'b00, target};
  assign in_ready   = (state == StIdle);
  assign busy       = (state != StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= StIdle;
      target     <= '0;
      a          <= '0;
      b          <= (WIDTH+2)'(1);
      idx        <= '0;
      out_valid  <= 1'b0;
      out_is_fib <= 1'b0;
      out_index  <= '0;
    end else begin
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            target <= in_value;
            a      <= '0;
            b      <= (WIDTH+2)'(1);
            idx    <= '0;
            state  <= StSearch;
          end
        end
        StSearch: begin
          if (a >= target_ext) begin
            out_is_fib <= (a == target_ext);
            out_index  <= idx;
            out_valid  <= 1'b1;
            state      <= StDone;
          end else begin
            a   <= b;
            b   <= a + b;
            idx <= idx + IDX_W'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_index_decoder.sv
// Directed bench for fib_index_decoder: hand-computed index/flag/latency vectors,
// backpressure and mid-search reset.
module tb_fib_index_decoder;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned IDX_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_value;
  logic             out_valid;
  logic             out_ready;
  logic             out_is_fib;
  logic [IDX_W-1:0] out_index;
  logic             busy;

  int tests = 0;
  int fails = 0;

  fib_index_decoder #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_value   (in_value),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_is_fib (out_is_fib),
    .out_index  (out_index),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present v for one accept edge, measure latency, compare result, optionally ack.
  task automatic run(input logic [WIDTH-1:0] v, input logic efib, input int eidx,
                     input int elat, input bit ack);
    int lat;
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    in_value = v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("busy_after_accept", busy, 1);
    lat = 0;
    while (lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (out_valid) break;
    end
    check("latency", lat, elat);
    check("out_is_fib", out_is_fib, efib);
    check("out_index", out_index, eidx);
    check("in_ready_done", in_ready, 0);
    if (ack) begin
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("out_valid_cleared", out_valid, 0);
      check("in_ready_after_ack", in_ready, 1);
      check("out_index_held", out_index, eidx);
    end
  endtask

  initial begin
    bit seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_value  = '0;
    out_ready = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_is_fib", out_is_fib, 0);
    check("rst_out_index", out_index, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;

    run(32'd0, 1'b1, 0, 1, 1'b1);
    run(32'd1, 1'b1, 1, 2, 1'b1);
    run(32'd8, 1'b1, 6, 7, 1'b1);
    run(32'd4, 1'b0, 5, 6, 1'b1);
    run(32'd2971215073, 1'b1, 47, 48, 1'b1);
    run(32'hFFFF_FFFF, 1'b0, 48, 49, 1'b1);

    // Backpressure: hold the result, try to sneak in another value.
    run(32'd5, 1'b1, 5, 6, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = (i == 2);
      in_value = 32'd3;
      check("bp_out_valid", out_valid, 1);
      check("bp_out_is_fib", out_is_fib, 1);
      check("bp_out_index", out_index, 5);
      check("bp_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_released", out_valid, 0);
    check("bp_in_ready_after", in_ready, 1);
    @(negedge clk);
    check("bp_not_accepted", busy, 0);
    run(32'd21, 1'b1, 8, 9, 1'b1);

    // Reset in the middle of a search.
    @(negedge clk);
    in_valid = 1'b1;
    in_value = 32'd1000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_index", out_index, 0);
    check("midrst_out_is_fib", out_is_fib, 0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      @(posedge clk);
      #1;
      seen |= out_valid;
    end
    check("aborted_no_result", seen, 0);
    run(32'd13, 1'b1, 7, 8, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
